// File: rtl/clock_enable_ctrl.sv
// Runtime-programmable clock-enable generator: free-run or counted bursts of
// one-cycle enable strobes at a period configured through a valid/ready port.
module clock_enable_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             stop,
  output logic             enable,
  output logic             busy,
  output logic             burst_done,
  output logic [1:0]       state_dbg
);

  // Config handshake: a transfer happens in a cycle where cfg_valid and
  // cfg_ready are both high; cfg_mode/period/count are sampled only then.
  // cfg_ready is low during a burst and in any cycle with stop or reset.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  localparam logic [1:0]       MODE_RUN   = 2'b01;
  localparam logic [1:0]       MODE_BURST = 2'b10;
  localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] period_r, period_n;
  logic [WIDTH-1:0] phase, phase_n;
  logic [CNT_W-1:0] remain, remain_n;
  logic             enable_n, done_n, busy_n;
  logic             accept;
  logic [WIDTH-1:0] period_cl;

  assign cfg_ready = (state != S_BURST) && !stop && !reset;
  assign accept    = cfg_valid && cfg_ready;
  assign period_cl = (cfg_period == '0) ? ONE_W : cfg_period;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      period_r   <= '0;
      phase      <= '0;
      remain     <= '0;
      enable     <= 1'b0;
      burst_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      period_r   <= period_n;
      phase      <= phase_n;
      remain     <= remain_n;
      enable     <= enable_n;
      burst_done <= done_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    period_n = period_r;
    phase_n  = phase;
    remain_n = remain;
    enable_n = 1'b0;
    done_n   = 1'b0;

    if (stop) begin
      state_n  = S_IDLE;
      phase_n  = '0;
      remain_n = '0;
    end else if (accept) begin
      // Every accept restarts the phase; the first strobe is the next cycle.
      period_n = period_cl;
      case (cfg_mode)
        MODE_RUN: begin
          state_n  = S_RUN;
          enable_n = 1'b1;
          phase_n  = period_cl - ONE_W;
        end
        MODE_BURST: begin
          if (cfg_count == '0) begin
            state_n  = S_IDLE;
            done_n   = 1'b1;
            phase_n  = '0;
            remain_n = '0;
          end else begin
            state_n  = S_BURST;
            enable_n = 1'b1;
            phase_n  = period_cl - ONE_W;
            remain_n = cfg_count - ONE_C;
          end
        end
        default: begin
          state_n  = S_IDLE;
          phase_n  = '0;
          remain_n = '0;
        end
      endcase
    end else begin
      case (state)
        S_RUN: begin
          if (phase == '0) begin
            enable_n = 1'b1;
            phase_n  = period_r - ONE_W;
          end else begin
            phase_n = phase - ONE_W;
          end
        end
        S_BURST: begin
          // remain reaches zero in the cycle of the last strobe, so done follows it.
          if (remain == '0) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            phase_n = '0;
          end else if (phase == '0) begin
            enable_n = 1'b1;
            phase_n  = period_r - ONE_W;
            remain_n = remain - ONE_C;
          end else begin
            phase_n = phase - ONE_W;
          end
        end
        default: ;
      endcase
    end

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Bench for clock_enable_ctrl: directed scenarios plus random traffic, all
// checked against a schedule model built from accept times and periods.
module tb_clock_enable_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_BURST = 2;

  logic             clk;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [WIDTH-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_count;
  logic             stop;
  logic             enable;
  logic             busy;
  logic             burst_done;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: what was last configured and when.
  int m_mode    = M_IDLE;
  int m_t0      = 0;
  int m_p       = 1;
  int m_n       = 0;
  int m_done_at = -1;

  clock_enable_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .stop       (stop),
    .enable     (enable),
    .busy       (busy),
    .burst_done (burst_done),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_enable(input int c);
    int k;
    if (m_mode == M_IDLE || c <= m_t0) return 1'b0;
    k = c - m_t0 - 1;
    if (k % m_p != 0) return 1'b0;
    if (m_mode == M_BURST && (k / m_p) >= m_n) return 1'b0;
    return 1'b1;
  endfunction

  // Outputs for the current cycle, sampled on the falling edge.
  task automatic check_outputs();
    bit exp_ready;
    exp_ready = (m_mode != M_BURST) && !stop && !reset;
    check("enable",     {31'd0, enable},     {31'd0, model_enable(cyc)});
    check("burst_done", {31'd0, burst_done}, {31'd0, (cyc == m_done_at)});
    check("busy",       {31'd0, busy},       {31'd0, (m_mode != M_IDLE)});
    check("cfg_ready",  {31'd0, cfg_ready},  {31'd0, exp_ready});
    check("state",      {30'd0, state_dbg},  m_mode);
  endtask

  // Advance the model across the rising edge that ends cycle cyc.
  task automatic model_edge();
    bit ready;
    int p;
    ready = (m_mode != M_BURST) && !stop && !reset;
    if (reset || stop) begin
      m_mode    = M_IDLE;
      m_done_at = -1;
    end else if (m_mode == M_BURST && cyc == m_t0 + 1 + (m_n - 1) * m_p) begin
      m_mode    = M_IDLE;
      m_done_at = cyc + 1;
    end else if (cfg_valid && ready) begin
      p = (cfg_period == 0) ? 1 : int'(cfg_period);
      if (cfg_mode == 2'b01) begin
        m_mode = M_RUN;
        m_t0   = cyc;
        m_p    = p;
      end else if (cfg_mode == 2'b10 && cfg_count == 0) begin
        m_mode    = M_IDLE;
        m_done_at = cyc + 1;
      end else if (cfg_mode == 2'b10) begin
        m_mode = M_BURST;
        m_t0   = cyc;
        m_p    = p;
        m_n    = int'(cfg_count);
      end else begin
        m_mode = M_IDLE;
      end
    end
  endtask

  // Driver: hold one set of inputs for one cycle, check, then step.
  task automatic cycle(input logic v, input logic [1:0] mode, input int per,
                       input int cnt, input logic st, input logic rst);
    cfg_valid  = v;
    cfg_mode   = mode;
    cfg_period = WIDTH'(per);
    cfg_count  = CNT_W'(cnt);
    stop       = st;
    reset      = rst;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [1:0] mode, input int per, input int cnt);
    cycle(1'b1, mode, per, cnt, 1'b0, 1'b0);
  endtask

  initial begin
    cfg_valid  = 1'b0;
    cfg_mode   = 2'b00;
    cfg_period = '0;
    cfg_count  = '0;
    stop       = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Checked reset cycles, then quiet idle
    cycle(1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
    idle(3);

    // Free-run P=4
    cfg(2'b01, 4, 0);
    idle(16);
    cfg(2'b00, 0, 0);
    idle(3);

    // Burst P=3 N=3 with cfg_valid held high throughout
    cfg(2'b10, 3, 3);
    for (int i = 0; i < 9; i++) cycle(1'b1, 2'b01, 7, 0, 1'b0, 1'b0);
    cfg(2'b00, 0, 0);
    idle(2);

    // Burst with period 0 (clamped) and with count 0
    cfg(2'b10, 0, 5);
    idle(8);
    cfg(2'b10, 6, 0);
    idle(4);

    // Free-run P=10, reconfigured to P=2 four cycles later
    cfg(2'b01, 10, 0);
    idle(3);
    cfg(2'b01, 2, 0);
    idle(12);
    cfg(2'b11, 9, 0);
    idle(3);

    // Burst P=4 N=8 aborted by stop with a simultaneous config request
    cfg(2'b10, 4, 8);
    idle(5);
    cycle(1'b1, 2'b01, 2, 0, 1'b1, 1'b0);
    idle(40);

    // Free-run P=5 interrupted by a one-cycle reset
    cfg(2'b01, 5, 0);
    idle(2);
    cycle(1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
    idle(12);
    cfg(2'b01, 3, 0);
    idle(7);

    // Burst with P=1, N=1 and a free-run at P=1
    cfg(2'b10, 1, 1);
    idle(3);
    cfg(2'b01, 1, 0);
    idle(4);
    cfg(2'b00, 0, 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic       v, st, rst;
      logic [1:0] md;
      int         per, cnt;
      v   = ($urandom_range(0, 9) == 0);
      md  = 2'($urandom_range(0, 3));
      per = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 40) : $urandom_range(0, 6);
      cnt = $urandom_range(0, 6);
      st  = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle(v, md, per, cnt, st, rst);
    end
    idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
